// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch stage: widths, trap/reset vectors,
// the NOP encoding and the next-PC source selector.
package fetch_unit_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic [2:0] {
        SelSeq,
        SelHold,
        SelRedirect,
        SelXadr,
        SelIllop
    } pc_sel_e;

    // The supervisor bit is the MSB of the PC.
    function automatic int unsigned sup_bit(input int unsigned xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/fetch_unit_irq_pending.sv
// Interrupt front end: rising-edge detect, pending latches with ack, and a
// masked lowest-index priority encoder.
module fetch_unit_irq_pending #(
    parameter int unsigned N_IRQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] mask,
    input  logic [N_IRQ-1:0] ack,
    output logic [N_IRQ-1:0] pending,
    output logic             any_masked,
    output logic [3:0]       id
);

    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pend_q;
    logic [N_IRQ-1:0] pend_d;
    logic [N_IRQ-1:0] masked;

    // A new rising edge wins over an ack in the same cycle.
    assign pend_d     = (pend_q & ~ack) | (irq & ~irq_q);
    assign masked     = pend_q & mask;
    assign any_masked = |masked;
    assign pending    = pend_q;

    always_comb begin
        id = 4'd0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                id = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= irq;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register with supervisor bit, trap/interrupt vectoring and
// the IF/ID pipeline register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEF,
    parameter int unsigned     N_IRQ     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [XLEN-1:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [XLEN-1:0] XADR_VEC  = XADR_VEC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic [XLEN-1:0]  imem_data_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             illop_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic [N_IRQ-1:0] irq_ack_i,
    output logic             if_valid_o,
    output logic [XLEN-1:0]  if_instr_o,
    output logic [XLEN-1:0]  if_pc_o,
    output logic [XLEN-1:0]  if_pc4_o,
    output logic             irq_take_o,
    output logic [3:0]       irq_id_o,
    output logic [XLEN-1:0]  epc_o,
    output logic [N_IRQ-1:0] irq_pending_o
);

    localparam int unsigned     Sup    = sup_bit(XLEN);
    localparam logic [Sup-1:0]  PcStep = Sup'(4);

    logic [XLEN-1:0] pc_q, pc_d, pc_seq;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_pc4_q, if_pc4_d;
    logic            irq_any;
    logic [3:0]      irq_id;
    logic            take;
    logic            bubble;
    pc_sel_e         pc_sel;

    fetch_unit_irq_pending #(
        .N_IRQ(N_IRQ)
    ) u_irq_pending (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq_i),
        .mask       (irq_mask_i),
        .ack        (irq_ack_i),
        .pending    (irq_pending_o),
        .any_masked (irq_any),
        .id         (irq_id)
    );

    // Increment never carries into the supervisor bit.
    assign pc_seq = {pc_q[Sup], pc_q[Sup-1:0] + PcStep};
    assign take   = irq_any & ~pc_q[Sup] & ~illop_i & ~redirect_valid_i & ~stall_i & ~reset;
    assign bubble = flush_i | illop_i | take | redirect_valid_i;

    always_comb begin
        pc_sel = SelSeq;
        if (illop_i) begin
            pc_sel = SelIllop;
        end else if (take) begin
            pc_sel = SelXadr;
        end else if (redirect_valid_i) begin
            pc_sel = SelRedirect;
        end else if (stall_i) begin
            pc_sel = SelHold;
        end
    end

    always_comb begin
        pc_d = pc_seq;
        unique case (pc_sel)
            SelIllop:    pc_d = ILLOP_VEC;
            SelXadr:     pc_d = XADR_VEC;
            SelRedirect: pc_d = redirect_target_i;
            SelHold:     pc_d = pc_q;
            default:     pc_d = pc_seq;
        endcase
    end

    always_comb begin
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        epc_d      = take ? pc_q : epc_q;
        if (bubble) begin
            if_valid_d = 1'b0;
            if_instr_d = XLEN'(NOP_INSTR);
        end else if (!stall_i) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_data_i;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_seq;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign if_valid_o  = if_valid_q;
    assign if_instr_o  = if_instr_q;
    assign if_pc_o     = if_pc_q;
    assign if_pc4_o    = if_pc4_q;
    assign epc_o       = epc_q;
    assign irq_take_o  = take;
    assign irq_id_o    = take ? irq_id : 4'd0;

endmodule
